ge_threshold_monitor: RTL and testbench



---
 rtl/ge_mon_pkg.sv | 14 +
 rtl/ge_cmp6.sv | 21 ++
 rtl/ge_threshold_monitor.sv | 164 ++++++++++++++++
 tb/tb_ge_threshold_monitor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ge_mon_pkg.sv
// rtl/ge_mon_pkg.sv - shared types and widths for the threshold monitor
package ge_mon_pkg;

  localparam int DATA_W = 6;
  localparam int RUN_W  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMING   = 2'd1,
    ALARM    = 2'd2,
    CLEARING = 2'd3
  } state_t;

endpackage

// File: rtl/ge_cmp6.sv
// rtl/ge_cmp6.sv - combinational 6-bit unsigned a >= b
module ge_cmp6
  import ge_mon_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_ge
);

  logic [2:0] w_gt;
  logic [2:0] w_eq;

  for (genvar k = 0; k < 3; k++) begin : g_slice
    assign w_gt[k] = (i_a[2*k +: 2] >  i_b[2*k +: 2]);
    assign w_eq[k] = (i_a[2*k +: 2] == i_b[2*k +: 2]);
  end

  // Most significant differing slice decides; all-equal counts as >=.
  assign o_ge = w_gt[2] | (w_eq[2] & (w_gt[1] | (w_eq[1] & (w_gt[0] | w_eq[0]))));

endmodule

// File: rtl/ge_threshold_monitor.sv
// rtl/ge_threshold_monitor.sv - sample >= threshold compare with debounced alarm and event count
module ge_threshold_monitor
  import ge_mon_pkg::*;
#(
  parameter int                CNT_ON  = 3,
  parameter int                CNT_OFF = 3,
  parameter int                EVT_W   = 8,
  parameter logic [DATA_W-1:0] THR_RST = 6'h20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              thr_wr,
  input  logic [DATA_W-1:0] thr_in,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ge_valid,
  output logic              ge_out,
  output logic              alarm,
  output logic              alarm_rise,
  input  logic              evt_clr,
  output logic [EVT_W-1:0]  evt_cnt
);

  if (CNT_ON < 1 || CNT_ON > 15) begin : g_bad_cnt_on
    $error("CNT_ON must be in 1..15");
  end
  if (CNT_OFF < 1 || CNT_OFF > 15) begin : g_bad_cnt_off
    $error("CNT_OFF must be in 1..15");
  end

  localparam logic [RUN_W-1:0] ON_L  = RUN_W'(CNT_ON);
  localparam logic [RUN_W-1:0] OFF_L = RUN_W'(CNT_OFF);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [RUN_W-1:0]  r_cnt;
  logic [RUN_W-1:0]  w_cnt_nxt;
  logic [RUN_W-1:0]  w_cnt_inc;
  logic [DATA_W-1:0] r_thr;
  logic              w_accept;
  logic              w_ge;
  logic              w_alarm_nxt;
  logic              w_rise_nxt;
  logic              r_ge_valid;
  logic              r_ge_out;
  logic              r_alarm;
  logic              r_rise;
  logic [EVT_W-1:0]  r_evt;

  assign s_ready   = !thr_wr;
  assign w_accept  = s_valid & s_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  ge_cmp6 u_cmp (
    .i_a  (s_data),
    .i_b  (r_thr),
    .o_ge (w_ge)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A threshold write abandons any partial run and falls back to the settled level.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (thr_wr) begin
      w_cnt_nxt = '0;
      if (r_state == ARMING)   w_state_nxt = IDLE;
      if (r_state == CLEARING) w_state_nxt = ALARM;
    end else if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (w_ge) begin
            if (ON_L == 4'd1) begin
              w_state_nxt = ALARM;
            end else begin
              w_state_nxt = ARMING;
              w_cnt_nxt   = 4'd1;
            end
          end
        end
        ARMING: begin
          if (!w_ge) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == ON_L) begin
            w_state_nxt = ALARM;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        ALARM: begin
          if (!w_ge) begin
            if (OFF_L == 4'd1) begin
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = CLEARING;
              w_cnt_nxt   = 4'd1;
            end
          end
        end
        CLEARING: begin
          if (w_ge) begin
            w_state_nxt = ALARM;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == OFF_L) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_alarm_nxt = (w_state_nxt == ALARM) || (w_state_nxt == CLEARING);
    w_rise_nxt  = (w_state_nxt == ALARM) && ((r_state == IDLE) || (r_state == ARMING));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_thr      <= THR_RST;
      r_ge_valid <= 1'b0;
      r_ge_out   <= 1'b0;
      r_alarm    <= 1'b0;
      r_rise     <= 1'b0;
      r_evt      <= '0;
    end else begin
      if (thr_wr) r_thr <= thr_in;
      r_ge_valid <= w_accept;
      if (w_accept) r_ge_out <= w_ge;
      r_alarm <= w_alarm_nxt;
      r_rise  <= w_rise_nxt;
      if (evt_clr) begin
        r_evt <= w_rise_nxt ? EVT_W'(1) : '0;
      end else if (w_rise_nxt && (r_evt != {EVT_W{1'b1}})) begin
        r_evt <= r_evt + 1'b1;
      end
    end
  end

  assign ge_valid   = r_ge_valid;
  assign ge_out     = r_ge_out;
  assign alarm      = r_alarm;
  assign alarm_rise = r_rise;
  assign evt_cnt    = r_evt;

endmodule

// File: tb/tb_ge_threshold_monitor.sv
// tb/tb_ge_threshold_monitor.sv - self-checking bench for ge_threshold_monitor
module tb_ge_threshold_monitor;

  localparam int CNT_ON   = 3;
  localparam int CNT_OFF  = 3;
  localparam int EVT_W    = 2;
  localparam int EVT_MAX  = (1 << EVT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             thr_wr = 1'b0;
  logic [5:0]       thr_in = '0;
  logic             s_valid = 1'b0;
  logic [5:0]       s_data = '0;
  logic             s_ready;
  logic             ge_valid;
  logic             ge_out;
  logic             alarm;
  logic             alarm_rise;
  logic             evt_clr = 1'b0;
  logic [EVT_W-1:0] evt_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ge_threshold_monitor #(
    .CNT_ON  (CNT_ON),
    .CNT_OFF (CNT_OFF),
    .EVT_W   (EVT_W),
    .THR_RST (6'h20)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .thr_wr     (thr_wr),
    .thr_in     (thr_in),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .ge_valid   (ge_valid),
    .ge_out     (ge_out),
    .alarm      (alarm),
    .alarm_rise (alarm_rise),
    .evt_clr    (evt_clr),
    .evt_cnt    (evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: alarm level flips after a run of opposing results long enough for that direction.
  logic [5:0] m_thr  = 6'h20;
  logic       m_gv   = 1'b0;
  logic       m_go   = 1'b0;
  logic       m_al   = 1'b0;
  logic       m_rise = 1'b0;
  int         m_run  = 0;
  int         m_evt  = 0;

  always @(posedge clk) begin : model
    logic acc, g, al, rise;
    int   run, evt;
    if (!reset_n) begin
      m_thr  <= 6'h20;
      m_gv   <= 1'b0;
      m_go   <= 1'b0;
      m_al   <= 1'b0;
      m_rise <= 1'b0;
      m_run  <= 0;
      m_evt  <= 0;
    end else begin
      acc  = s_valid && !thr_wr;
      al   = m_al;
      run  = m_run;
      rise = 1'b0;
      evt  = m_evt;
      g    = m_go;
      if (thr_wr) begin
        m_thr <= thr_in;
        run = 0;
      end else if (acc) begin
        g = (int'(s_data) >= int'(m_thr));
        if (g != al) begin
          run++;
          if (run == (al ? CNT_OFF : CNT_ON)) begin
            al   = g;
            run  = 0;
            rise = g;
          end
        end else begin
          run = 0;
        end
      end
      if (evt_clr) evt = rise ? 1 : 0;
      else if (rise && evt < EVT_MAX) evt++;
      m_gv   <= acc;
      m_go   <= g;
      m_al   <= al;
      m_rise <= rise;
      m_run  <= run;
      m_evt  <= evt;
    end
  end

  always @(negedge clk) begin
    chk("mdl_s_ready", s_ready, !thr_wr);
    chk("mdl_ge_valid", ge_valid, m_gv);
    chk("mdl_ge_out", ge_out, m_go);
    chk("mdl_alarm", alarm, m_al);
    chk("mdl_alarm_rise", alarm_rise, m_rise);
    chk("mdl_evt_cnt", evt_cnt, m_evt);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] d);
    s_valid = 1'b1;
    s_data  = d;
    cyc();
    s_valid = 1'b0;
  endtask

  task automatic wthr(input logic [5:0] v);
    thr_wr = 1'b1;
    thr_in = v;
    cyc();
    thr_wr = 1'b0;
  endtask

  task automatic sendn(input logic [5:0] d, input int n);
    for (int i = 0; i < n; i++) send(d);
  endtask

  initial begin
    #1;
    repeat (3) cyc();
    chk("rst_alarm", alarm, 0);
    chk("rst_evt", evt_cnt, 0);
    chk("rst_ge_valid", ge_valid, 0);
    reset_n = 1'b1;
    cyc();
    chk("rst_s_ready", s_ready, 1);

    send(6'd32);  chk("thr_rst_32", ge_out, 1); chk("thr_rst_gv", ge_valid, 1);
    send(6'd31);  chk("thr_rst_31", ge_out, 0);
    cyc();        chk("gv_idle", ge_valid, 0);

    wthr(6'd0);   send(6'd0);  chk("zero_ge_zero", ge_out, 1);
    wthr(6'd63);  send(6'd63); chk("max_ge_max", ge_out, 1);
    send(6'd0);   chk("zero_ge_max", ge_out, 0);

    wthr(6'd20);
    send(6'd25);  chk("raise_ge1", ge_out, 1); chk("raise_al1", alarm, 0);
    send(6'd20);  chk("raise_ge2", ge_out, 1); chk("raise_al2", alarm, 0);
    send(6'd40);  chk("raise_ge3", ge_out, 1); chk("raise_al3", alarm, 1);
    chk("raise_rise", alarm_rise, 1); chk("raise_evt", evt_cnt, 1);
    cyc();        chk("rise_one_cycle", alarm_rise, 0);

    sendn(6'd5, 2); chk("hys_hold_a", alarm, 1);
    send(6'd30);    chk("hys_hold_b", alarm, 1);
    sendn(6'd5, 2); chk("hys_hold_c", alarm, 1);
    send(6'd5);     chk("hys_drop", alarm, 0); chk("hys_no_rise", alarm_rise, 0);

    send(6'd25);
    repeat (4) begin cyc(); chk("gap_gv", ge_valid, 0); end
    send(6'd25);  chk("gap_al", alarm, 0);
    send(6'd10);  chk("abort_al", alarm, 0);
    sendn(6'd25, 2); chk("abort_idle", alarm, 0);
    send(6'd25);  chk("abort_rearm", alarm, 1); chk("abort_evt", evt_cnt, 2);

    sendn(6'd5, 3); chk("col_pre", alarm, 0);
    send(6'd25);
    thr_wr = 1'b1; thr_in = 6'd50; s_valid = 1'b1; s_data = 6'd40;
    #1 chk("col_s_ready", s_ready, 0);
    cyc();        chk("col_no_accept", ge_valid, 0);
    thr_wr = 1'b0;
    cyc();        chk("col_reissue_gv", ge_valid, 1); chk("col_reissue_ge", ge_out, 0);
    s_valid = 1'b0;

    wthr(6'd20);  send(6'd25); wthr(6'd20);
    sendn(6'd25, 2); chk("arm_revert", alarm, 0);
    send(6'd25);  chk("arm_revert_rise", alarm_rise, 1); chk("evt_3", evt_cnt, 3);

    send(6'd5);   wthr(6'd20);
    sendn(6'd5, 2); chk("clr_revert", alarm, 1);
    send(6'd5);   chk("clr_revert_drop", alarm, 0);

    sendn(6'd25, 3); chk("sat_rise4", alarm_rise, 1); chk("sat_evt4", evt_cnt, 3);
    sendn(6'd5, 3);
    sendn(6'd25, 3); chk("sat_evt5", evt_cnt, 3);
    sendn(6'd5, 3);
    sendn(6'd25, 2);
    evt_clr = 1'b1;
    send(6'd25);  chk("clr_with_rise", evt_cnt, 1);
    evt_clr = 1'b0;
    sendn(6'd5, 3);
    evt_clr = 1'b1;
    cyc();        chk("clr_alone", evt_cnt, 0);
    evt_clr = 1'b0;

    sendn(6'd25, 3); chk("pre_rst_al", alarm, 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_al", alarm, 0);
    chk("async_rst_evt", evt_cnt, 0);
    chk("async_rst_ge", ge_out, 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();        chk("rel_no_rise", alarm_rise, 0); chk("rel_al", alarm, 0);
    send(6'd31);  chk("rel_thr_rst", ge_out, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
